// File: rtl/imm_gen_pipe_pkg.sv
// Immediate format codes and the shared decode helper for the immediate pipeline.
// Latency: none (pure types, constants and combinational function).
// Backpressure: not applicable.
package imm_gen_pipe_pkg;

    // Immediate format select codes driven on in_imm_src; code 7 is reserved.
    localparam logic [2:0] IMM_I_TYPE = 3'd0;
    localparam logic [2:0] IMM_S_TYPE = 3'd1;
    localparam logic [2:0] IMM_B_TYPE = 3'd2;
    localparam logic [2:0] IMM_U_TYPE = 3'd3;
    localparam logic [2:0] IMM_J_TYPE = 3'd4;
    localparam logic [2:0] IMM_R_TYPE = 3'd5;
    localparam logic [2:0] IMM_Z_TYPE = 3'd6;

    // Decode at full 64-bit width; a 32-bit datapath takes the low half, which is
    // exactly the 32-bit result because every format sign-extends from instr[31].
    function automatic logic [63:0] imm_decode(input logic [31:0] instr,
                                               input logic [2:0]  src);
        logic [63:0] imm;
        imm = '0;
        case (src)
            IMM_I_TYPE: imm = {{52{instr[31]}}, instr[31:20]};
            IMM_S_TYPE: imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B_TYPE: imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25],
                               instr[11:8], 1'b0};
            IMM_U_TYPE: imm = {{32{instr[31]}}, instr[31:12], 12'b0};
            IMM_J_TYPE: imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20],
                               instr[30:21], 1'b0};
            IMM_Z_TYPE: imm = {59'b0, instr[19:15]};
            default:    imm = '0;   // R-type and reserved code carry no immediate
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry skid buffer (main + skid) carrying an opaque payload between valid/ready ports.
// Latency: 1 cycle from input transfer to out_vld when empty; 1 transfer/cycle sustained.
// Backpressure: in_rdy is a flop, low only while the skid entry is occupied; no out_rdy->in_rdy path.
module skid_buffer #(
    parameter int W = 37
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);

    logic         main_vld;
    logic [W-1:0] main_dat;
    logic         skid_vld;
    logic [W-1:0] skid_dat;

    // Ready depends only on the skid flop, so upstream never sees a combinational path.
    assign in_rdy  = ~skid_vld;
    assign out_vld = main_vld;
    assign out_dat = main_dat;

    // Occupancy and data update; reset beats flush, flush beats both transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            main_dat <= '0;
            skid_dat <= '0;
        end else if (flush) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (skid_vld) begin
            // Full: input is blocked, so only a drain can happen; skid moves up to main.
            if (out_rdy) begin
                main_dat <= skid_dat;
                skid_vld <= 1'b0;
            end
        end else if (in_vld) begin
            // Main is free or being drained this cycle: new entry lands in main.
            // Otherwise main is stalled and the new entry parks in skid.
            if (!main_vld || out_rdy) begin
                main_vld <= 1'b1;
                main_dat <= in_dat;
            end else begin
                skid_vld <= 1'b1;
                skid_dat <= in_dat;
            end
        end else if (main_vld && out_rdy) begin
            main_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Decodes the immediate of an instruction word and registers it with its tag.
// Latency: 1 cycle from input transfer to out_valid when empty.
// Backpressure: 2-entry skid buffer; in_ready registered, drops only when both entries are held.
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN  = 32,   // 32 or 64
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag
);

    localparam int PW = XLEN + TAG_W;

    logic [XLEN-1:0] imm_ext;
    logic [PW-1:0]   pay_in;
    logic [PW-1:0]   pay_out;
    logic            unused_opcode;

    // The opcode field never contributes to any immediate format.
    assign unused_opcode = ^in_instr[6:0];

    // Immediate is formed before the register stage so the stored entry is final.
    assign imm_ext = XLEN'(imm_decode(in_instr, in_imm_src));
    assign pay_in  = {imm_ext, in_tag};

    skid_buffer #(
        .W (PW)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .in_vld  (in_valid),
        .in_rdy  (in_ready),
        .in_dat  (pay_in),
        .out_vld (out_valid),
        .out_rdy (out_ready),
        .out_dat (pay_out)
    );

    // Imm and tag travel as one payload so they can never separate.
    assign out_imm = pay_out[PW-1:TAG_W];
    assign out_tag = pay_out[TAG_W-1:0];

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [2:0]  in_imm_src = '0;
    logic [4:0]  in_tag = '0;
    logic        out_ready = 1'b0;

    logic        in_ready64, in_ready32, out_valid64, out_valid32;
    logic [63:0] out_imm64;
    logic [31:0] out_imm32;
    logic [4:0]  out_tag64, out_tag32;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64), .out_tag(out_tag64)
    );

    imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32), .out_tag(out_tag32)
    );

    typedef struct {
        logic [63:0] imm;
        logic [4:0]  tag;
    } ent_t;

    ent_t       q[$];        // accepted, not yet consumed, oldest first
    logic [4:0] drained[$];  // tags seen leaving the output port
    bit         zero_out = 1'b1;
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Sign-extend an n-bit unsigned field by arithmetic, giving its two's complement value.
    function automatic logic [63:0] sext(input longint raw, input int n);
        longint v;
        v = raw;
        if (raw >= (longint'(1) << (n - 1))) v = raw - (longint'(1) << n);
        return 64'(v);
    endfunction

    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src);
        longint w, raw;
        w = longint'(ins);
        case (src)
            3'd0: return sext((w >> 20) & 'hFFF, 12);
            3'd1: return sext((((w >> 25) & 'h7F) << 5) + ((w >> 7) & 'h1F), 12);
            3'd2: begin
                raw = (((w >> 31) & 1) << 12) + (((w >> 7) & 1) << 11)
                    + (((w >> 25) & 'h3F) << 5) + (((w >> 8) & 'hF) << 1);
                return sext(raw, 13);
            end
            3'd3: return sext(w & 'hFFFFF000, 32);
            3'd4: begin
                raw = (((w >> 31) & 1) << 20) + (((w >> 12) & 'hFF) << 12)
                    + (((w >> 20) & 1) << 11) + (((w >> 21) & 'h3FF) << 1);
                return sext(raw, 21);
            end
            3'd6: return 64'((w >> 15) & 'h1F);
            default: return 64'd0;
        endcase
    endfunction

    task automatic check_state();
        chk("out_valid64", 64'(out_valid64), 64'(q.size() > 0));
        chk("out_valid32", 64'(out_valid32), 64'(q.size() > 0));
        chk("in_ready64", 64'(in_ready64), 64'(q.size() < 2));
        chk("in_ready32", 64'(in_ready32), 64'(q.size() < 2));
        if (q.size() > 0) begin
            chk("out_imm64", out_imm64, q[0].imm);
            chk("out_imm32", 64'(out_imm32), 64'(q[0].imm[31:0]));
            chk("out_tag64", 64'(out_tag64), 64'(q[0].tag));
            chk("out_tag32", 64'(out_tag32), 64'(q[0].tag));
        end else if (zero_out) begin
            chk("rst_imm64", out_imm64, 64'd0);
            chk("rst_tag32", 64'(out_tag32), 64'd0);
        end
    endtask

    // One clock: check at negedge, then advance the model with the inputs sampled at posedge.
    task automatic cycle();
        bit   acc, con;
        ent_t e;
        @(negedge clk);
        check_state();
        acc   = in_valid && (q.size() < 2);
        con   = out_ready && (q.size() > 0);
        e.imm = ref_imm(in_instr, in_imm_src);
        e.tag = in_tag;
        if (con && !rst) drained.push_back(out_tag64);
        @(posedge clk);
        if (rst) begin
            q.delete();
            zero_out = 1'b1;
        end else if (flush) begin
            q.delete();
        end else begin
            if (con) void'(q.pop_front());
            if (acc) begin
                q.push_back(e);
                zero_out = 1'b0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    // Load one entry with the output stalled, check it, then drain it.
    task automatic single(input string name, input logic [31:0] ins, input logic [2:0] src,
                          input logic [4:0] tag, input logic [63:0] exp);
        in_valid = 1'b1; in_instr = ins; in_imm_src = src; in_tag = tag; out_ready = 1'b0;
        cycle();
        in_valid = 1'b0;
        chk({name, "_vld"}, 64'(out_valid64), 64'd1);
        chk({name, "_imm64"}, out_imm64, exp);
        chk({name, "_imm32"}, 64'(out_imm32), 64'(exp[31:0]));
        chk({name, "_tag"}, 64'(out_tag64), 64'(tag));
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
    endtask

    task automatic fill_two(input logic [4:0] t0, input logic [4:0] t1);
        out_ready = 1'b0; in_valid = 1'b1; in_imm_src = 3'd0;
        in_instr = $urandom; in_tag = t0; cycle();
        in_instr = $urandom; in_tag = t1; cycle();
        in_valid = 1'b0;
        chk("fill_in_ready", 64'(in_ready64), 64'd0);
    endtask

    initial begin
        logic [4:0] offers[4];
        int         k;
        bit         acc;

        offers = '{5'd1, 5'd2, 5'd3, 5'd4};
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        chk("reset_in_ready", 64'(in_ready64), 64'd1);
        chk("reset_out_valid", 64'(out_valid64), 64'd0);

        // Known immediates, including 64-bit-only results
        single("i_neg1", 32'hFFF00093, 3'd0, 5'd3, 64'hFFFFFFFFFFFFFFFF);
        single("b_neg4", 32'hFE000EE3, 3'd2, 5'd4, 64'hFFFFFFFFFFFFFFFC);
        single("s_neg4", 32'hFE112E23, 3'd1, 5'd5, 64'hFFFFFFFFFFFFFFFC);
        single("u_rv64", 32'h800000B7, 3'd3, 5'd6, 64'hFFFFFFFF80000000);
        single("z_zimm", 32'h000FD073, 3'd6, 5'd7, 64'h000000000000001F);
        single("j_neg2", 32'hFFFFF06F, 3'd4, 5'd8, 64'hFFFFFFFFFFFFFFFE);
        single("r_zero", 32'hFFFFFFFF, 3'd5, 5'd9, 64'd0);
        single("rsv7",   32'hFFFFFFFF, 3'd7, 5'd10, 64'd0);

        // Stall for 3 cycles while offering tags 1..4, then release
        drained.delete();
        k = 0;
        for (int c = 0; c < 12; c++) begin
            out_ready  = (c >= 3);
            in_valid   = (k < 4);
            in_tag     = (k < 4) ? offers[k] : 5'd0;
            in_instr   = $urandom;
            in_imm_src = 3'($urandom_range(0, 7));
            acc = in_valid && (q.size() < 2);
            cycle();
            if (acc) k++;
            if (c == 1) chk("stall_in_ready", 64'(in_ready64), 64'd0);
        end
        in_valid = 1'b0;
        chk("order_count", 64'(drained.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            chk("order_tag", 64'((i < drained.size()) ? drained[i] : 5'h1F), 64'(offers[i]));

        // Flush with both entries held and a competing input
        fill_two(5'd20, 5'd21);
        drained.delete();
        flush = 1'b1; in_valid = 1'b1; in_tag = 5'd22;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 64'(out_valid64), 64'd0);
        chk("flush_in_ready", 64'(in_ready64), 64'd1);
        out_ready = 1'b1;
        repeat (3) cycle();
        chk("flush_no_leak", 64'(drained.size()), 64'd0);

        // Reset with both entries held
        fill_two(5'd11, 5'd12);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("midrst_out_valid", 64'(out_valid64), 64'd0);
        chk("midrst_in_ready", 64'(in_ready64), 64'd1);
        chk("midrst_imm", out_imm64, 64'd0);
        chk("midrst_tag", 64'(out_tag64), 64'd0);

        // Random traffic against the queue model
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 399) == 0);
            flush      = ($urandom_range(0, 39) == 0);
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = (i % 500 < 100) ? 1'b1 : ($urandom_range(0, 2) != 0);
            in_instr   = $urandom;
            in_imm_src = 3'($urandom_range(0, 7));
            in_tag     = 5'($urandom_range(0, 31));
            cycle();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
